// File: rtl/tqvp_arb_pkg.sv
// Shared types and strobe encodings for the two-requester register bus arbiter.
package tqvp_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Peripheral strobe encoding: access width, or idle
  localparam logic [1:0] STRB_8    = 2'b00;
  localparam logic [1:0] STRB_16   = 2'b01;
  localparam logic [1:0] STRB_32   = 2'b10;
  localparam logic [1:0] STRB_IDLE = 2'b11;

  function automatic logic strobe_active(input logic [1:0] strobe);
    return strobe != STRB_IDLE;
  endfunction

endpackage

// File: rtl/tqvp_arb_pick.sv
// Grant selection between requesters 0 and 1 (grant=1 selects requester 1).
// TQVP_ARB_ROUND_ROBIN_EN enables round-robin with a last-served flag; otherwise r0 has fixed priority.
module tqvp_arb_pick
  import tqvp_arb_pkg::*;
(
`ifdef TQVP_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst_n,
  input  logic take,
`endif
  input  logic req0,
  input  logic req1,
  output logic grant
);

`ifdef TQVP_ARB_ROUND_ROBIN_EN
  // Resets to 1 so requester 0 wins the first contested grant
  logic last_served;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= 1'b1;
    end else if (take) begin
      last_served <= grant;
    end
  end

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_served;
    end else if (req1) begin
      grant = 1'b1;
    end
  end
`else
  always_comb begin
    grant = !req0 && req1;
  end
`endif

endmodule

// File: rtl/tqvp_reg_bus_arbiter.sv
// Two-requester register bus arbiter: IDLE/WRITE/READ/DONE FSM with read timeout.
// Arbitration mode selected by TQVP_ARB_ROUND_ROBIN_EN (see tqvp_arb_pick).
module tqvp_reg_bus_arbiter
  import tqvp_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        r0_req,
  input  logic [5:0]  r0_address,
  input  logic [31:0] r0_data_in,
  input  logic [1:0]  r0_write_n,
  input  logic [1:0]  r0_read_n,
  output logic        r0_ack,

  input  logic        r1_req,
  input  logic [5:0]  r1_address,
  input  logic [31:0] r1_data_in,
  input  logic [1:0]  r1_write_n,
  input  logic [1:0]  r1_read_n,
  output logic        r1_ack,

  output logic [31:0] rd_data,
  output logic        rd_err,

  output logic [5:0]  address,
  output logic [31:0] data_in,
  output logic [1:0]  data_write_n,
  output logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_ready
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        gnt;
  logic [1:0]  wr_lat;
  logic [1:0]  rd_lat;
  logic [7:0]  cnt;

  logic        any_req;
  logic        take;
  logic        pick;
  logic [5:0]  sel_address;
  logic [31:0] sel_data;
  logic [1:0]  sel_wr;
  logic [1:0]  sel_rd;
  logic        well_formed;

  assign any_req = r0_req || r1_req;
  assign take    = (state == ST_IDLE) && any_req;

  tqvp_arb_pick u_pick (
`ifdef TQVP_ARB_ROUND_ROBIN_EN
    .clk   (clk),
    .rst_n (rst_n),
    .take  (take),
`endif
    .req0  (r0_req),
    .req1  (r1_req),
    .grant (pick)
  );

  always_comb begin
    sel_address = pick ? r1_address : r0_address;
    sel_data    = pick ? r1_data_in : r0_data_in;
    sel_wr      = pick ? r1_write_n : r0_write_n;
    sel_rd      = pick ? r1_read_n  : r0_read_n;
    well_formed = strobe_active(sel_wr) ^ strobe_active(sel_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gnt     <= 1'b0;
      wr_lat  <= STRB_IDLE;
      rd_lat  <= STRB_IDLE;
      cnt     <= '0;
      address <= '0;
      data_in <= '0;
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt     <= pick;
            address <= sel_address;
            data_in <= sel_data;
            wr_lat  <= sel_wr;
            rd_lat  <= sel_rd;
            cnt     <= '0;
            // Malformed requests skip the bus and complete with an error
            rd_err  <= !well_formed;
            if (!well_formed) begin
              state <= ST_DONE;
            end else if (strobe_active(sel_wr)) begin
              state <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          state <= ST_DONE;
        end
        ST_READ: begin
          if (data_ready) begin
            rd_data <= data_out;
            rd_err  <= 1'b0;
            state   <= ST_DONE;
          end else if (cnt == TIMEOUT_LAST) begin
            rd_data <= '0;
            rd_err  <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes and acks decode from state so reset idles them asynchronously
  always_comb begin
    data_write_n = (state == ST_WRITE) ? wr_lat : STRB_IDLE;
    data_read_n  = (state == ST_READ)  ? rd_lat : STRB_IDLE;
    r0_ack       = (state == ST_DONE) && !gnt;
    r1_ack       = (state == ST_DONE) && gnt;
  end

endmodule

// File: tb/tb_tqvp_reg_bus_arbiter.sv
// Directed self-checking bench for tqvp_reg_bus_arbiter; expectations follow TQVP_ARB_ROUND_ROBIN_EN.
module tb_tqvp_reg_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        r0_req, r1_req;
  logic [5:0]  r0_address, r1_address;
  logic [31:0] r0_data_in, r1_data_in;
  logic [1:0]  r0_write_n, r1_write_n;
  logic [1:0]  r0_read_n, r1_read_n;
  logic        r0_ack, r1_ack;
  logic [31:0] rd_data;
  logic        rd_err;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  int unsigned n_checks;
  int unsigned n_fail;

  tqvp_reg_bus_arbiter #(.TIMEOUT_CYCLES(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r0_req       (r0_req),
    .r0_address   (r0_address),
    .r0_data_in   (r0_data_in),
    .r0_write_n   (r0_write_n),
    .r0_read_n    (r0_read_n),
    .r0_ack       (r0_ack),
    .r1_req       (r1_req),
    .r1_address   (r1_address),
    .r1_data_in   (r1_data_in),
    .r1_write_n   (r1_write_n),
    .r1_read_n    (r1_read_n),
    .r1_ack       (r1_ack),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_out     (data_out),
    .data_ready   (data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin : stim
    int unsigned strobes;
    logic        seen;
    logic        exp_gnt;
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    r0_req     = 1'b0;  r1_req     = 1'b0;
    r0_address = '0;    r1_address = '0;
    r0_data_in = '0;    r1_data_in = '0;
    r0_write_n = 2'b11; r1_write_n = 2'b11;
    r0_read_n  = 2'b11; r1_read_n  = 2'b11;
    data_out   = '0;
    data_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_write_n", 32'(data_write_n), 32'h3);
    check_eq("rst_read_n",  32'(data_read_n),  32'h3);
    check_eq("rst_address", 32'(address),      32'h0);
    check_eq("rst_data_in", data_in,           32'h0);
    check_eq("rst_rd_data", rd_data,           32'h0);
    check_eq("rst_rd_err",  32'(rd_err),       32'h0);
    check_eq("rst_acks",    {30'd0, r1_ack, r0_ack}, 32'h0);
    rst_n = 1'b1;
    tick();

    // r0 write: strobe in cycle 1, ack in cycle 2
    r0_address = 6'h04; r0_data_in = 32'h5A; r0_write_n = 2'b10; r0_read_n = 2'b11;
    r0_req = 1'b1;
    tick();
    check_eq("wr_c1_write_n", 32'(data_write_n), 32'h2);
    check_eq("wr_c1_read_n",  32'(data_read_n),  32'h3);
    check_eq("wr_c1_address", 32'(address),      32'h04);
    check_eq("wr_c1_data_in", data_in,           32'h5A);
    check_eq("wr_c1_ack0",    32'(r0_ack),       32'h0);
    tick();
    check_eq("wr_c2_ack0",    32'(r0_ack),       32'h1);
    check_eq("wr_c2_ack1",    32'(r1_ack),       32'h0);
    check_eq("wr_c2_rd_err",  32'(rd_err),       32'h0);
    check_eq("wr_c2_write_n", 32'(data_write_n), 32'h3);
    r0_req = 1'b0;
    tick();
    check_eq("wr_c3_ack0",    32'(r0_ack),       32'h0);
    check_eq("wr_c3_address", 32'(address),      32'h04);

    // r1 read, data_ready arrives after 3 strobe cycles
    r1_address = 6'h08; r1_write_n = 2'b11; r1_read_n = 2'b10;
    data_out = 32'hCAFE0000;
    r1_req = 1'b1;
    tick();
    check_eq("rd_c1_read_n", 32'(data_read_n), 32'h2);
    check_eq("rd_c1_addr",   32'(address),     32'h08);
    tick();
    tick();
    check_eq("rd_c3_read_n", 32'(data_read_n), 32'h2);
    check_eq("rd_c3_ack1",   32'(r1_ack),      32'h0);
    data_ready = 1'b1; data_out = 32'hDEADBEEF;
    tick();
    check_eq("rd_ack1",    32'(r1_ack),      32'h1);
    check_eq("rd_data",    rd_data,          32'hDEADBEEF);
    check_eq("rd_err",     32'(rd_err),      32'h0);
    check_eq("rd_idle_n",  32'(data_read_n), 32'h3);
    r1_req = 1'b0; data_ready = 1'b0;
    tick();

    // data_ready already high: one strobe cycle, and ignored while IDLE
    r0_address = 6'h10; r0_write_n = 2'b11; r0_read_n = 2'b01;
    data_ready = 1'b1; data_out = 32'h00001234;
    r0_req = 1'b1;
    tick();
    check_eq("fast_c1_read_n", 32'(data_read_n), 32'h1);
    check_eq("fast_c1_ack0",   32'(r0_ack),      32'h0);
    tick();
    check_eq("fast_c2_ack0",   32'(r0_ack),      32'h1);
    check_eq("fast_c2_rd",     rd_data,          32'h00001234);
    r0_req = 1'b0;
    tick();
    data_ready = 1'b0;

    // Read timeout: 32 strobe cycles then error ack with rd_data cleared
    r0_address = 6'h20; r0_write_n = 2'b11; r0_read_n = 2'b10;
    data_out = 32'hFFFFFFFF;
    r0_req = 1'b1;
    strobes = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (r0_ack) begin
        seen = 1'b1;
        break;
      end
      if (data_read_n != 2'b11) strobes++;
    end
    check_eq("to_ack_seen", 32'(seen),    32'h1);
    check_eq("to_strobes",  strobes,      32'd32);
    check_eq("to_rd_data",  rd_data,      32'h0);
    check_eq("to_rd_err",   32'(rd_err),  32'h1);
    r0_req = 1'b0;
    tick();

    // Malformed: both strobes idle
    r1_address = 6'h0C; r1_write_n = 2'b11; r1_read_n = 2'b11;
    r1_req = 1'b1;
    tick();
    check_eq("mal_idle_ack1",  32'(r1_ack),       32'h1);
    check_eq("mal_idle_err",   32'(rd_err),       32'h1);
    check_eq("mal_idle_wr_n",  32'(data_write_n), 32'h3);
    check_eq("mal_idle_rd_n",  32'(data_read_n),  32'h3);
    r1_req = 1'b0;
    tick();

    // Malformed: both strobes active
    r0_write_n = 2'b10; r0_read_n = 2'b10;
    r0_req = 1'b1;
    tick();
    check_eq("mal_both_ack0", 32'(r0_ack), 32'h1);
    check_eq("mal_both_err",  32'(rd_err), 32'h1);
    check_eq("mal_both_rd_n", 32'(data_read_n), 32'h3);
    r0_req = 1'b0;
    tick();

    // Reset during READ aborts with no ack; next request is served normally
    r1_address = 6'h08; r1_write_n = 2'b11; r1_read_n = 2'b10;
    r1_req = 1'b1;
    tick();
    check_eq("abort_pre_rd_n", 32'(data_read_n), 32'h2);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("abort_rd_n", 32'(data_read_n), 32'h3);
    check_eq("abort_ack1", 32'(r1_ack),      32'h0);
    #1;
    r1_req = 1'b0;
    rst_n = 1'b1;
    tick();
    check_eq("abort_post_ack1", 32'(r1_ack),      32'h0);
    check_eq("abort_post_rd_n", 32'(data_read_n), 32'h3);
    r0_address = 6'h03; r0_data_in = 32'h77; r0_write_n = 2'b00; r0_read_n = 2'b11;
    r0_req = 1'b1;
    tick();
    check_eq("post_wr_n",  32'(data_write_n), 32'h0);
    check_eq("post_addr",  32'(address),      32'h03);
    tick();
    check_eq("post_ack0",  32'(r0_ack),       32'h1);
    r0_req = 1'b0;
    tick();

    // Contention with both requests held: 4 back-to-back transactions
    pulse_reset();
    r0_address = 6'h11; r0_write_n = 2'b10; r0_read_n = 2'b11;
    r1_address = 6'h22; r1_write_n = 2'b10; r1_read_n = 2'b11;
    r0_req = 1'b1; r1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef TQVP_ARB_ROUND_ROBIN_EN
      exp_gnt = (k % 2) == 1;
`else
      exp_gnt = 1'b0;
`endif
      tick();
      check_eq($sformatf("arb%0d_addr", k), 32'(address), exp_gnt ? 32'h22 : 32'h11);
      tick();
      check_eq($sformatf("arb%0d_acks", k), {30'd0, r1_ack, r0_ack},
               exp_gnt ? 32'h2 : 32'h1);
      if (k == 3) begin
        r0_req = 1'b0; r1_req = 1'b0;
      end
      tick();
    end
    check_eq("arb_end_acks", {30'd0, r1_ack, r0_ack}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tqvp_reg_bus_arbiter.md
TQVP_REG_BUS_ARBITER -- requirements
Module: tqvp_reg_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32: maximum read-strobe cycles before a forced error completion; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 rN_req  input  1  (N=0,1) transaction request from requester N; held high until rN_ack.
REQ-005 rN_address  input  6  (N=0,1) register address.
REQ-006 rN_data_in  input  32  (N=0,1) write data.
REQ-007 rN_write_n  input  2  (N=0,1) write strobe, peripheral encoding (2'b11 = idle).
REQ-008 rN_read_n  input  2  (N=0,1) read strobe, peripheral encoding (2'b11 = idle).
REQ-009 rN_ack  output  1  (N=0,1) one-cycle completion pulse to requester N.
REQ-010 rd_data  output  32  read result, valid in the ack cycle and held until the next ack.
REQ-011 rd_err  output  1  error flag (timeout or malformed request), valid with ack.
REQ-012 address  output  6  peripheral register address.
REQ-013 data_in  output  32  peripheral write data.
REQ-014 data_write_n  output  2  peripheral write strobe.
REQ-015 data_read_n  output  2  peripheral read strobe.
REQ-016 data_out  input  32  peripheral read data.
REQ-017 data_ready  input  1  peripheral read-data-valid indication.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE, READ and DONE.
REQ-019 In IDLE, the grant decision, address, data and strobes SHALL be latched from the winning requester when any rN_req is high.
- Well-formed request (exactly one of write_n or read_n non-idle): next state WRITE or READ.
- Malformed request (both strobes idle or both non-idle): next state DONE with rd_err=1, and no bus cycle is issued.
REQ-020 Arbitration: with both requests high, the requester not served last SHALL win (round-robin); the last-served flag resets to 1, so r0 wins first.
REQ-021 WRITE SHALL drive the latched data_write_n for exactly one cycle and then go to DONE; data_ready SHALL be ignored in WRITE.
REQ-022 READ SHALL hold the latched data_read_n and count cycles.
- data_ready=1: capture data_out into rd_data, rd_err=0, go to DONE.
- Count reaching TIMEOUT_CYCLES without data_ready: rd_data=0, rd_err=1, go to DONE.
REQ-023 If data_ready is already high in the first READ cycle, the read SHALL complete after exactly one strobe cycle.
REQ-024 DONE SHALL pulse rN_ack of the granted requester for one cycle, with all strobes idle, then return to IDLE.
REQ-025 Latency: a request sampled in IDLE at cycle 0 gives a write strobe in cycle 1 and ack in cycle 2; a read acks 1 cycle after data_ready is sampled.
REQ-026 Outside WRITE and READ, data_write_n and data_read_n SHALL be 2'b11, and address and data_in SHALL hold their last latched values.
REQ-027 A request dropped before ack SHALL still complete and ack; requester inputs are not resampled until the next IDLE.
REQ-028 A request still high in the IDLE cycle after its ack SHALL be treated as a new transaction, subject to arbitration.
REQ-029 data_ready SHALL be ignored in IDLE and DONE.

Reset
REQ-030 When rst_n=0: state IDLE; strobes 2'b11; address=0; data_in=0; rd_data=0; rd_err=0; both acks 0; counter 0; last-served=1.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately, idle the strobes asynchronously and produce no ack.

Configuration
REQ-032 With TQVP_ARB_ROUND_ROBIN_EN defined, arbitration SHALL follow REQ-020.
REQ-033 Without TQVP_ARB_ROUND_ROBIN_EN, r0 SHALL always win simultaneous requests and the last-served flag SHALL not exist.

Structure
REQ-034 Shared package tqvp_arb_pkg SHALL hold the FSM state type and the strobe encoding constants (idle 2'b11; 8/16/32-bit widths).
REQ-035 One sub-module, tqvp_arb_pick, SHALL implement the grant selection, including the last-served flag; the FSM and datapath remain in the top module.

Verification
REQ-036 r0 write, address 0x04, data 0x5A, write_n=2'b10 -> data_write_n=2'b10 for one cycle at cycle 1; r0_ack at cycle 2; rd_err=0.
REQ-037 r1 read, address 0x08; data_ready raised 3 cycles into the strobe with data_out=0xDEADBEEF -> r1_ack, rd_data=0xDEADBEEF, rd_err=0.
REQ-038 r0 and r1 request simultaneously and repeatedly -> grants r0, r1, r0, r1; with the macro undefined, r0 every time.
REQ-039 Read with data_ready never asserted, TIMEOUT_CYCLES=32 -> strobe held 32 cycles, then ack with rd_data=0 and rd_err=1.
REQ-040 Request with both strobes 2'b11 -> ack 1 cycle later with rd_err=1 and no strobe activity.
REQ-041 rst_n pulsed low during a READ -> data_read_n=2'b11 immediately, no ack, and the next request is served normally.
